// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store controller: funct3 codes, FSM states
// and the access-size decode.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_D  = 3'b011;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [2:0] F3_WU = 3'b110;

    typedef enum logic [2:0] {
        IDLE,
        BEAT0,
        BEAT1,
        WAIT,
        FAULT,
        RESP
    } lsu_state_e;

    function automatic logic [3:0] size_bytes(input logic [2:0] funct3);
        case (funct3[1:0])
            2'b00:   return 4'd1;
            2'b01:   return 4'd2;
            2'b10:   return 4'd4;
            default: return 4'd8;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational datapath: legality/split detection, store lane shifting with
// byte masks, and load realignment with sign/zero extension.
module lsu_align
    import lsu_pkg::*;
#(
    parameter int unsigned XLEN           = 32,
    parameter bit          MISALIGN_SPLIT = 1'b1
) (
    input  logic                         we_i,
    input  logic [2:0]                   funct3_i,
    input  logic [$clog2(XLEN/8)-1:0]    offset_i,
    input  logic [XLEN-1:0]              wdata_i,
    input  logic [XLEN-1:0]              rdata_lo_i,
    input  logic [XLEN-1:0]              rdata_hi_i,
    output logic                         fault_o,
    output logic                         split_o,
    output logic [XLEN-1:0]              wdata_lo_o,
    output logic [XLEN-1:0]              wdata_hi_o,
    output logic [XLEN/8-1:0]            wmask_lo_o,
    output logic [XLEN/8-1:0]            wmask_hi_o,
    output logic [XLEN-1:0]              rdata_o
);

    localparam int unsigned NB  = XLEN / 8;
    localparam int unsigned NB2 = 2 * NB;

    logic [3:0]        size;
    logic [4:0]        end_byte;
    logic              legal;
    logic              misaligned;
    logic [2*XLEN-1:0] wimg;
    logic [NB2-1:0]    wmsk;
    logic [XLEN-1:0]   lraw;

    assign size       = size_bytes(funct3_i);
    assign end_byte   = 5'(offset_i) + 5'(size);
    assign split_o    = end_byte > 5'(NB);
    assign misaligned = (4'(offset_i) & (size - 4'd1)) != 4'd0;

    always_comb begin
        legal = 1'b0;
        case (funct3_i)
            F3_B, F3_H, F3_W: legal = 1'b1;
            F3_D:             legal = (XLEN == 64);
            F3_BU, F3_HU:     legal = !we_i;
            F3_WU:            legal = !we_i && (XLEN == 64);
            default:          legal = 1'b0;
        endcase
    end

    assign fault_o = !legal || (!MISALIGN_SPLIT && misaligned);

    assign wimg = {{XLEN{1'b0}}, wdata_i} << {offset_i, 3'b000};
    assign wmsk = NB2'((16'd1 << size) - 16'd1) << offset_i;
    assign {wdata_hi_o, wdata_lo_o} = wimg;
    assign {wmask_hi_o, wmask_lo_o} = wmsk;

    assign lraw = XLEN'({rdata_hi_i, rdata_lo_i} >> {offset_i, 3'b000});

    always_comb begin
        rdata_o = '0;
        case (funct3_i)
            F3_B:    rdata_o = XLEN'($signed(lraw[7:0]));
            F3_H:    rdata_o = XLEN'($signed(lraw[15:0]));
            F3_W:    rdata_o = XLEN'($signed(lraw[31:0]));
            F3_D:    rdata_o = lraw;
            F3_BU:   rdata_o = XLEN'(lraw[7:0]);
            F3_HU:   rdata_o = XLEN'(lraw[15:0]);
            F3_WU:   rdata_o = XLEN'(lraw[31:0]);
            default: rdata_o = '0;
        endcase
    end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store controller between the MEM stage and a 1-cycle-latency data RAM;
// misaligned accesses may be split into two RAM beats.
module lsu_mem_ctrl
    import lsu_pkg::*;
#(
    parameter int unsigned XLEN           = 32,
    parameter int unsigned ADDR_W         = 32,
    parameter bit          MISALIGN_SPLIT = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [2:0]          req_funct3,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [XLEN-1:0]     req_wdata,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [XLEN-1:0]     rsp_rdata,
    output logic                rsp_fault,
    output logic                mem_en,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [XLEN-1:0]     mem_wdata,
    output logic [XLEN/8-1:0]   mem_wmask,
    input  logic [XLEN-1:0]     mem_rdata
);

    localparam int unsigned NB = XLEN / 8;
    localparam int unsigned OW = $clog2(NB);

    lsu_state_e          state_q, state_d;
    logic                we_q, we_d;
    logic [2:0]          f3_q, f3_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [XLEN-1:0]     wdata_q, wdata_d;
    logic [XLEN-1:0]     lo_q, lo_d;
    logic [XLEN-1:0]     rdata_q, rdata_d;
    logic                fault_q, fault_d;

    logic                in_idle;
    logic                a_we;
    logic [2:0]          a_f3;
    logic [OW-1:0]       a_off;
    logic                a_fault, a_split;
    logic [XLEN-1:0]     a_rlo, a_rhi, a_wlo, a_whi, a_rdata;
    logic [NB-1:0]       a_mlo, a_mhi;
    logic [ADDR_W-1:0]   base;

    // While idle the decoder looks at the incoming request so the fault
    // decision is ready at accept time; afterwards it sees the held request.
    assign in_idle = (state_q == IDLE);
    assign a_we    = in_idle ? req_we : we_q;
    assign a_f3    = in_idle ? req_funct3 : f3_q;
    assign a_off   = in_idle ? req_addr[OW-1:0] : addr_q[OW-1:0];
    assign a_rlo   = a_split ? lo_q : mem_rdata;
    assign a_rhi   = a_split ? mem_rdata : '0;
    assign base    = {addr_q[ADDR_W-1:OW], {OW{1'b0}}};

    lsu_align #(
        .XLEN           (XLEN),
        .MISALIGN_SPLIT (MISALIGN_SPLIT)
    ) u_align (
        .we_i       (a_we),
        .funct3_i   (a_f3),
        .offset_i   (a_off),
        .wdata_i    (wdata_q),
        .rdata_lo_i (a_rlo),
        .rdata_hi_i (a_rhi),
        .fault_o    (a_fault),
        .split_o    (a_split),
        .wdata_lo_o (a_wlo),
        .wdata_hi_o (a_whi),
        .wmask_lo_o (a_mlo),
        .wmask_hi_o (a_mhi),
        .rdata_o    (a_rdata)
    );

    always_comb begin
        state_d   = state_q;
        we_d      = we_q;
        f3_d      = f3_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        lo_d      = lo_q;
        rdata_d   = rdata_q;
        fault_d   = fault_q;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_wmask = '0;

        case (state_q)
            IDLE: begin
                req_ready = !rst;
                if (req_valid && !rst) begin
                    we_d    = req_we;
                    f3_d    = req_funct3;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    rdata_d = '0;
                    fault_d = 1'b0;
                    state_d = a_fault ? FAULT : BEAT0;
                end
            end
            BEAT0: begin
                // A beat is suppressed while reset is held so an abandoned
                // split store never reaches the RAM.
                if (!rst) begin
                    mem_en    = 1'b1;
                    mem_we    = we_q;
                    mem_addr  = base;
                    mem_wdata = a_wlo;
                    mem_wmask = we_q ? a_mlo : '0;
                end
                state_d = a_split ? BEAT1 : WAIT;
            end
            BEAT1: begin
                if (!rst) begin
                    mem_en    = 1'b1;
                    mem_we    = we_q;
                    mem_addr  = base + ADDR_W'(NB);
                    mem_wdata = a_whi;
                    mem_wmask = we_q ? a_mhi : '0;
                end
                lo_d    = mem_rdata;
                state_d = WAIT;
            end
            WAIT: begin
                rdata_d = we_q ? '0 : a_rdata;
                fault_d = 1'b0;
                state_d = RESP;
            end
            FAULT: begin
                rdata_d = '0;
                fault_d = 1'b1;
                state_d = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            f3_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            lo_q    <= '0;
            rdata_q <= '0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            f3_q    <= f3_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            lo_q    <= lo_d;
            rdata_q <= rdata_d;
            fault_q <= fault_d;
        end
    end

    assign rsp_rdata = rdata_q;
    assign rsp_fault = fault_q;

endmodule
